// File: rtl/gcd_pkg.sv
// Shared types for the GCD core and its operand packer.
package gcd_pkg;

  localparam int W = 16;

  typedef logic [2*W-1:0] gcd_pair_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pair_state_e;

endpackage

// File: rtl/gcd_fifo.sv
// Synchronous FIFO of operand pairs with occupancy count; head word is read straight from storage.
module gcd_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  gcd_pair_t     push_data,
  input  logic          pop,
  output gcd_pair_t     head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  gcd_pair_t     mem_q [DEPTH];
  gcd_pair_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset clears storage so the head reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gcd_operand_packer.sv
// Pairs a 16-bit operand stream into {a, b} words for the GCD core, dropping pairs with a zero half.
module gcd_operand_packer
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [2*W-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic [7:0]    drop_cnt
);

  pair_state_e  state_q, state_d;
  logic [W-1:0] held_q, held_d;
  logic [7:0]   drop_q, drop_d;
  gcd_pair_t    pair_s;
  logic         form_s;
  logic         zero_s;
  logic         push_s;
  logic         accept_s;
  logic         full_s;
  logic         empty_s;

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign drop_cnt  = drop_q;
  assign accept_s  = in_valid && !full_s;

  // Pairing FSM: hold the first operand, or self-pair a lone final operand.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    pair_s  = '0;
    form_s  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept_s) begin
          if (in_last) begin
            pair_s = {in_data, in_data};
            form_s = 1'b1;
          end else begin
            held_d  = in_data;
            state_d = HALF;
          end
        end else begin
          state_d = EMPTY;
        end
      end
      HALF: begin
        if (accept_s) begin
          pair_s  = {held_q, in_data};
          form_s  = 1'b1;
          state_d = EMPTY;
        end else begin
          state_d = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Zero filter: GCD never terminates on a zero operand, so such pairs are counted instead.
  always_comb begin
    zero_s = (pair_s[2*W-1:W] == {W{1'b0}}) || (pair_s[W-1:0] == {W{1'b0}});
    push_s = form_s && !zero_s;
    if (form_s && zero_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Pairing state, held operand and drop counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      held_q  <= {W{1'b0}};
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      drop_q  <= drop_d;
    end
  end

  gcd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (pair_s),
    .pop       (out_ready),
    .head_data (out_data),
    .count     (count),
    .full      (full_s),
    .empty     (empty_s)
  );

endmodule

// File: tb/tb_gcd_operand_packer.sv
// Directed and random stimulus for gcd_operand_packer checked against a queue-based pairing model.
module tb_gcd_operand_packer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = 16'h0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          m_half = 1'b0;
  logic [15:0] m_held = 16'h0;
  int          m_drop = 0;

  gcd_operand_packer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".out_data"}, out_data, mq[0]);
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  // One clock of stimulus: model the edge from the rules, then compare.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic r, input string tag);
    bit          acc;
    bit          formed;
    logic [31:0] pair;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    acc    = v && (mq.size() != DEPTH);
    formed = 1'b0;
    pair   = 32'h0;
    if (acc) begin
      if (m_half) begin
        pair = {m_held, d}; formed = 1'b1; m_half = 1'b0;
      end else if (l) begin
        pair = {d, d}; formed = 1'b1;
      end else begin
        m_held = d; m_half = 1'b1;
      end
    end
    if (r && mq.size() != 0) void'(mq.pop_front());
    if (formed) begin
      if (pair[31:16] == 16'h0 || pair[15:0] == 16'h0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back(pair);
      end
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [15:0] rd;
    // reset state
    #3;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", out_data, 32'h0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // basic pair
    step(1'b1, 16'h0030, 1'b0, 1'b1, "basic1");
    step(1'b1, 16'h0020, 1'b0, 1'b1, "basic2");
    chk("basic.pair", out_data, 32'h0030_0020);
    chk("basic.valid", 32'(out_valid), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b1, "basic.drain");

    // fill and backpressure
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b0, "fill");
    chk("fill.count", 32'(count), 32'(DEPTH));
    chk("fill.in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 16'h00AA, 1'b0, 1'b0, "fill.blocked");
    chk("fill.blocked_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 16'h0, 1'b0, 1'b1, "drain");
    chk("drain.count", 32'(count), 32'd0);

    // odd stream
    step(1'b1, 16'h0011, 1'b1, 1'b0, "odd1");
    chk("odd.self_pair", out_data, 32'h0011_0011);
    step(1'b0, 16'h0, 1'b0, 1'b1, "odd.drain");
    step(1'b1, 16'h0003, 1'b0, 1'b1, "odd2");
    step(1'b1, 16'h0007, 1'b1, 1'b0, "odd3");
    chk("odd.last_in_half", out_data, 32'h0003_0007);
    step(1'b0, 16'h0, 1'b0, 1'b1, "odd.drain2");

    // zero drop
    step(1'b1, 16'h0000, 1'b0, 1'b0, "zero1");
    step(1'b1, 16'h0005, 1'b0, 1'b0, "zero2");
    step(1'b1, 16'h0009, 1'b0, 1'b0, "zero3");
    step(1'b1, 16'h0006, 1'b0, 1'b0, "zero4");
    chk("zero.drop", 32'(drop_cnt), 32'd1);
    chk("zero.count", 32'(count), 32'd1);
    chk("zero.head", out_data, 32'h0009_0006);

    // simultaneous push and pop at count=1
    step(1'b1, 16'h0021, 1'b0, 1'b0, "sim.a");
    step(1'b1, 16'h0022, 1'b0, 1'b1, "sim.pushpop");
    chk("sim.count1", 32'(count), 32'd1);
    chk("sim.order", out_data, 32'h0021_0022);
    // at count=DEPTH: operand is refused while the pop proceeds
    for (int i = 0; i < 2 * (DEPTH - 1); i++) step(1'b1, 16'(i + 16'h40), 1'b0, 1'b0, "sim.fill");
    step(1'b1, 16'h0077, 1'b0, 1'b1, "sim.full_pop");
    chk("sim.full_count", 32'(count), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b0, 1'b1, "sim.drain");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      step($urandom_range(0, 3) != 0, rd, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, "rand");
    end

    // drop counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, 16'h0, 1'b1, 1'b1, "sat");
    chk("sat.drop", 32'(drop_cnt), 32'd255);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0, 1'b0, 1'b1, "sat.drain");

    // reset mid-operation
    step(1'b1, 16'h0031, 1'b0, 1'b0, "mid.p1");
    step(1'b1, 16'h0032, 1'b0, 1'b0, "mid.p2");
    step(1'b1, 16'h0033, 1'b0, 1'b0, "mid.p3");
    step(1'b1, 16'h0034, 1'b0, 1'b0, "mid.p4");
    step(1'b1, 16'h0030, 1'b0, 1'b0, "mid.half");
    chk("mid.queued", 32'(count), 32'd2);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    m_half = 1'b0;
    m_drop = 0;
    chk("mid.count", 32'(count), 32'd0);
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    chk("mid.drop", 32'(drop_cnt), 32'd0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h0004, 1'b0, 1'b0, "post.a");
    step(1'b1, 16'h0002, 1'b0, 1'b0, "post.b");
    chk("post.pair", out_data, 32'h0004_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_operand_packer.md
# gcd_operand_packer

Upstream feeder for the `GCD` core. It accepts a stream of 16-bit operands and pairs consecutive operands into the 32-bit `{a, b}` word that `GCD` consumes on `in_data`. Completed pairs are buffered in a small FIFO and presented on a valid/ready interface that connects directly to `GCD.in_valid/in_data/in_ready`. Pairs containing a zero operand are dropped and counted, because the GCD core does not terminate on zero.

## Interface
- `W`, 16, operand width; a pair is `2*W` bits.
- `DEPTH`, 4, FIFO depth in pairs; power of two, ≥ 2.
- `CW`, `$clog2(DEPTH)+1`, width of `count`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand present.
- `in_data`  in  W  operand.
- `in_last`  in  1  operand is the final operand of a stream; sampled only on an accepted beat.
- `in_ready`  out  1  operand accepted when `in_valid && in_ready`.
- `out_valid`  out  1  head pair valid; drives `GCD.in_valid`.
- `out_data`  out  2W  head pair `{a, b}`; drives `GCD.in_data`.
- `out_ready`  in  1  pair consumed when `out_valid && out_ready`; driven by `GCD.in_ready`.
- `count`  out  CW  FIFO occupancy, 0..DEPTH.
- `drop_cnt`  out  8  number of dropped zero-operand pairs; saturates at 255.

## Operation
- Pairing FSM has two states:
  - `EMPTY`: no held operand.
  - `HALF`: operand `a` is held in a register.
- `EMPTY`, accepted beat, `in_last=0`: store `a`, go to `HALF`.
- `EMPTY`, accepted beat, `in_last=1`: form `{x, x}` (GCD(x,x)=x), push it, stay in `EMPTY`.
- `HALF`, accepted beat: form `{a, in_data}`, push it, go to `EMPTY`. `in_last` is ignored in this state.
- Packing rules:
  - First operand goes in `[2W-1:W]`, second in `[W-1:0]`.
  - No arithmetic and no reordering.
- Zero filter:
  - A formed pair with either half equal to 0 is not pushed.
  - `drop_cnt` increments by 1 on such a pair, saturating at 255.
  - The FSM advances exactly as it would for a pushed pair.
- FIFO:
  - Order is preserved.
  - The head pair appears on `out_data` while `out_valid=1`.
  - `out_data` holds its value until the pair is popped.
- `in_ready = (count != DEPTH)`. This applies in both states and is independent of `out_ready`; there is no full-FIFO pass-through.
- Push and pop in the same cycle are both allowed; `count` is then unchanged.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `count=0`, `drop_cnt=0`, FSM in `EMPTY`, FIFO cleared.
- Reset applied mid-pair discards the held operand and all FIFO contents immediately.
- Latency: a pair is pushed on the edge that accepts its completing beat. On the following cycle:
  - `out_valid=1` (if the FIFO was empty);
  - `count` reflects the push.
- `in_ready` and `out_valid` are registered-state functions with no combinational path from `in_valid` or `out_ready`.
- Full boundary: `count` reaches DEPTH on the edge of the DEPTH-th push, and `in_ready` falls in the next cycle. A pop in that next cycle raises `in_ready` one cycle later.
- Empty boundary: popping the last pair drops `out_valid` on the next cycle unless a push happens on the same edge.
- Pointers wrap modulo DEPTH; occupancy is tracked by `count`.

## Structure
- Package `gcd_pkg` holds:
  - `W`;
  - `typedef logic [2*W-1:0] gcd_pair_t`;
  - the pairing-state enum `{EMPTY, HALF}`.
  `GCD` and its bench share this package.
- Sub-module `gcd_fifo` (parameters `DEPTH`, element `gcd_pair_t`) implements the synchronous FIFO with `count`.
- The top level contains the pairing FSM, the held-operand register, the zero filter and `drop_cnt`.

## Test plan
- Basic pair: after reset, send `0x0030` then `0x0020` with `out_ready=1`. Required: one cycle after the second accept, `out_valid=1` and `out_data=0x0030_0020`. When chained into `GCD`, `out_data` of `GCD` becomes 16.
- Fill and backpressure: hold `out_ready=0` and send 2·DEPTH nonzero operands. Required: `count` reaches 4 and `in_ready=0` thereafter. Then drain with `out_ready=1`; pairs leave in send order and `count` returns to 0.
- Odd stream: in `EMPTY`, send `0x0011` with `in_last=1`. Required: `out_data=0x0011_0011`. Then send `0x0007` with `in_last=1` while in `HALF` after `0x0003`; required: `0x0003_0007`.
- Zero drop: send `0x0000`, `0x0005`, then `0x0009`, `0x0006`. Required: `drop_cnt=1` and only `0x0009_0006` appears. Drop 256 pairs; `drop_cnt` stays at 255.
- Simultaneous push and pop at `count=1` with `out_ready=1`: `count` stays 1 and the data order is preserved. Repeat at `count=DEPTH`: no push occurs because `in_ready=0`.
- Reset mid-operation: accept `0x0030` (FSM in `HALF`) with 2 pairs queued, then pulse `reset` low asynchronously. Required: `count=0`, `out_valid=0`, `in_ready=1` immediately. The next `0x0004`, `0x0002` yields `0x0004_0002`.
